// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_pkg;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_WIDTH      = 32;
    localparam int WB_ZERO_REG   = 0;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_WIDTH-1:0]      data;
    } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Forwarding lookup: finds the youngest occupied queue entry whose address matches.
// Latency: purely combinational.
// Backpressure: none; it only observes the queue contents.
module wb_match
    import wb_pkg::*;
#(
    parameter int WIDTH      = WB_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]      ent_data,
    input  logic [DEPTH-1:0]                 occ,
    input  logic [PTR_W-1:0]                 head,
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             hit,
    output logic [WIDTH-1:0]                 data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (addr != ADDR_WIDTH'(WB_ZERO_REG) && occ[idx] && ent_addr[idx] == addr) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue in front of the register-file write port, with read forwarding.
// Latency: accepted request reaches the write port one cycle later at the earliest (same cycle if WB_QUEUE_BYPASS_EN).
// Backpressure: in_ready = !full from registered state; wb_stall holds the head entry in place.
module wb_queue
    import wb_pkg::*;
#(
    parameter int WIDTH      = WB_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       wb_stall,
    output logic                       we,
    output logic [ADDR_WIDTH-1:0]      addrw,
    output logic [WIDTH-1:0]           dinw,
    input  logic [ADDR_WIDTH-1:0]      addra,
    input  logic [ADDR_WIDTH-1:0]      addrb,
    output logic                       hit_a,
    output logic                       hit_b,
    output logic [WIDTH-1:0]           fwd_a,
    output logic [WIDTH-1:0]           fwd_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
    logic [DEPTH-1:0][WIDTH-1:0]      ent_data;
    logic [DEPTH-1:0]                 occ;
    logic [PTR_W-1:0]                 head;
    logic [PTR_W-1:0]                 tail;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             in_nz;
    logic                             bypass;
    logic                             push;
    logic                             pop;

    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign in_nz    = (in_addr != ADDR_WIDTH'(WB_ZERO_REG));

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass = empty && !wb_stall && in_valid && in_nz;
`else
    assign bypass = 1'b0;
`endif

    // x0 requests complete the handshake but are dropped here.
    assign push = in_valid && in_ready && in_nz && !bypass;
    assign pop  = !empty && !wb_stall;

    always_comb begin
        we    = pop || bypass;
        addrw = '0;
        dinw  = '0;
        if (pop) begin
            addrw = ent_addr[head];
            dinw  = ent_data[head];
        end else if (bypass) begin
            addrw = in_addr;
            dinw  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            occ   <= '0;
        end else begin
            if (push) begin
                occ[tail] <= 1'b1;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                occ[head] <= 1'b0;
                head      <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset; occupancy bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= in_addr;
            ent_data[tail] <= in_data;
        end
    end

    wb_match #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_match_a (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .occ      (occ),
        .head     (head),
        .addr     (addra),
        .hit      (hit_a),
        .data     (fwd_a)
    );

    wb_match #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_match_b (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .occ      (occ),
        .head     (head),
        .addr     (addrb),
        .hit      (hit_b),
        .data     (fwd_b)
    );
endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue: a stimulus process records accepted requests, a monitor checks every cycle.
// The reference model is an ordered list of pending writes; WB_QUEUE_BYPASS_EN is honoured when defined.
module tb_wb_queue;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [AW-1:0]    in_addr = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic             wb_stall = 1'b0;
    logic [AW-1:0]    addra = '0;
    logic [AW-1:0]    addrb = '0;

    logic             in_ready, we, hit_a, hit_b, empty, full;
    logic [AW-1:0]    addrw;
    logic [WIDTH-1:0] dinw, fwd_a, fwd_b;
    logic [CW-1:0]    count;

    wb_queue #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
        .we(we), .addrw(addrw), .dinw(dinw), .addra(addra), .addrb(addrb),
        .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        bit               byp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   byp_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending (non-bypassed) write to a register; sb is oldest-first.
    function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [WIDTH-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            foreach (sb[i]) begin
                if (!sb[i].byp && sb[i].addr == a) begin
                    h = 1'b1;
                    d = sb[i].data;
                end
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        int               n;
        logic             h;
        logic [WIDTH-1:0] d;
        exp_t             e;
        if (mon_en) begin
            n = 0;
            foreach (sb[i]) if (!sb[i].byp) n++;
            chk("count", 64'(count), 64'(n));
            chk("empty", 64'(empty), 64'(n == 0));
            chk("full", 64'(full), 64'(n == DEPTH));
            chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
            lookup(addra, h, d);
            chk("hit_a", 64'(hit_a), 64'(h));
            chk("fwd_a", 64'(fwd_a), 64'(d));
            lookup(addrb, h, d);
            chk("hit_b", 64'(hit_b), 64'(h));
            chk("fwd_b", 64'(fwd_b), 64'(d));
            chk("we", 64'(we), 64'(sb.size() != 0 && !wb_stall));
            if (we === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL write_unexpected: got addrw=%0h dinw=%0h expected no write", addrw, dinw);
                end else begin
                    e = sb.pop_front();
                    chk("addrw", 64'(addrw), 64'(e.addr));
                    chk("dinw", 64'(dinw), 64'(e.data));
                end
            end else begin
                chk("addrw_idle", 64'(addrw), 64'(0));
                chk("dinw_idle", 64'(dinw), 64'(0));
            end
        end
    end

    // Drive one cycle of stimulus at posedge+1, record the handshake at negedge+1.
    task automatic step(input bit v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input bit st);
        exp_t e;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wb_stall = st;
        byp_now  = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
        if (!rst && sb.size() == 0 && !st && v && a != 0) begin
            e.addr = a; e.data = d; e.byp = 1'b1;
            sb.push_back(e);
            byp_now = 1'b1;
        end
`endif
        @(negedge clk);
        #1;
        if (rst) begin
            sb.delete();
        end else if (in_valid && in_ready && in_addr != 0 && !byp_now) begin
            e.addr = in_addr; e.data = in_data; e.byp = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        repeat (2) step(1'b0, '0, '0, 1'b0);
        step(1'b1, 5'd5, 32'hAAAA_0001, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b0);

        for (int i = 3; i <= 6; i++) step(1'b1, AW'(i), 32'h100 + 32'(i), 1'b1);
        step(1'b1, 5'd8, 32'hDEAD_0008, 1'b1);
        repeat (6) step(1'b0, '0, '0, 1'b0);

        step(1'b1, 5'd7, 32'h11, 1'b1);
        step(1'b1, 5'd7, 32'h22, 1'b1);
        addra = 5'd7;
        addrb = 5'd0;
        step(1'b0, '0, '0, 1'b1);
        repeat (4) step(1'b0, '0, '0, 1'b0);

        step(1'b1, 5'd0, 32'hBAD0_0000, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b0);

        for (int i = 1; i <= 3; i++) step(1'b1, AW'(i + 10), 32'h300 + 32'(i), 1'b1);
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        repeat (3) step(1'b0, '0, '0, 1'b0);

        step(1'b1, 5'd9, 32'h55, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b0);

        for (int c = 0; c < 1500; c++) begin
            addra = AW'($urandom_range(0, 7));
            addrb = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step(($urandom_range(0, 3) != 0) && !rst, AW'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 7)));
            rst = 1'b0;
        end

        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            step(1'b0, '0, '0, 1'b0);
            budget++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d writes still pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
